gshare_index_ctrl: RTL and testbench
====================================

# gshare_index_ctrl

Initiator-side controller for the 256-entry pattern history table. For each fetched branch it forms a gshare index from the branch PC and a speculative global history register (GHR), and issues a prediction request to the table. It holds a checkpoint of each outstanding branch in an in-order queue. When a branch resolves, it issues the table update at the same index and repairs the GHR if the branch was mispredicted. It sits between the fetch/branch-unit logic and the PHT.

## Interface
Parameters:
- HIST_W, 8: GHR and PHT index width. Fixed at 8 to match the 256-entry table.
- DEPTH, 4: maximum outstanding (unresolved) branches. Must be a power of 2, ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- br_valid  in  1  fetched branch presented this cycle.
- br_pc  in  HIST_W  low PC bits of the branch.
- br_ready  out  1  branch accepted this cycle.
- pred_valid  out  1  br_valid & br_ready.
- pred_taken  out  1  prediction for the accepted branch.
- res_valid  in  1  oldest outstanding branch resolved.
- res_taken  in  1  actual outcome of that branch.
- res_ready  out  1  queue non-empty, so the resolution is accepted.
- mispredict  out  1  registered pulse: the last accepted resolution differed from its prediction.
- pht_addr  out  HIST_W  table index.
- pht_request  out  1  prediction lookup.
- pht_result  out  1  update strobe.
- pht_taken  out  1  update outcome.
- pht_prediction  in  1  table output for pht_addr (combinational).

## Operation
- **Queue entry:** {idx[HIST_W], ghr_before[HIST_W], pred}. Entries are resolved strictly in order, oldest first.
- **Resolve cycle:** occurs when res_valid & res_ready.
  - pht_result=1, pht_taken=res_taken, pht_addr=head.idx, pht_request=0.
  - The queue pops at the edge.
- **Predict cycle:** occurs when br_valid & br_ready and no resolve is taking place.
  - idx = br_pc ^ ghr.
  - pht_addr=idx, pht_request=1, pred_taken=pht_prediction.
  - At the edge: push {idx, ghr, pht_prediction}, then ghr <= {ghr[HIST_W-2:0], pht_prediction}.
- **Handshake signals:**
  - br_ready = !full & !(res_valid & res_ready).
  - Resolution has priority over prediction because only one pht_addr is available per cycle.
- **Idle:** pht_request=pht_result=0, pht_addr=br_pc^ghr, pht_taken=0.
- **Mispredict** (res_taken != head.pred on a resolve cycle), at the edge:
  - ghr <= {head.ghr_before[HIST_W-2:0], res_taken}.
  - All entries are flushed, so count goes to 0. Younger entries are wrong-path.
  - mispredict <= 1 for exactly one cycle.
- **Correct resolution:** pop only. ghr unchanged, mispredict <= 0.
- **res_valid while the queue is empty:** ignored (res_ready=0). No table update, no state change.
- **Pointers:** wrap modulo DEPTH. count runs 0..DEPTH. full means count==DEPTH.

## Timing
- **Reset values:**
  - ghr=0, count=0, rd_ptr=wr_ptr=0, mispredict=0.
  - br_ready=1, res_ready=0, pht_request=pht_result=0, pht_addr=br_pc.
- **Combinational paths:**
  - Prediction is zero-latency: pred_taken is combinational from pht_prediction in the accepting cycle.
  - The PHT strobes and address are combinational from the current state and inputs. The table samples them on the same edge.
- **mispredict:** asserts the cycle after the resolving edge.
- **GHR visibility:** the next branch sees the updated GHR on the very next cycle, for both back-to-back predictions and post-mispredict repair.
- **Reset mid-operation:** asserting rst clears the queue and GHR immediately (asynchronously). The table contents are untouched.

## Structure
- **Shared include/package:**
  - HIST_W default.
  - PHT_ENTRIES = 1<<HIST_W.
  - Queue-entry field widths/offsets (ENTRY_W = 2*HIST_W+1).
- **Sub-module `branch_ckpt_fifo`:** DEPTH×ENTRY_W synchronous FIFO with push, pop, flush, head data (combinational read), full, empty, and async active-high reset.
- **Top-level logic:** GHR, index XOR, arbitration, and mispredict register.

## Test plan
- **Reset, then first prediction:** br_pc=0x3C, ghr=0, pht_prediction=1 → pht_addr=0x3C, pht_request=1, pred_taken=1. Next cycle ghr=0x01.
- **Back-to-back predictions:** predictions 1, 0, 1 on pc=0x10, 0x10, 0x10 → addrs 0x10, 0x11, 0x12. Final ghr=0x05, count=3.
- **Correct resolution:** head {idx 0x3C, pred 1}, res_taken=1 → pht_result=1, pht_addr=0x3C, pht_taken=1. Count decrements, ghr unchanged, mispredict stays 0.
- **Mispredict:** 3 outstanding entries, head ghr_before=0x00, pred=1, res_taken=0 → update at head.idx with taken=0. Next cycle count=0, ghr=0x00, mispredict=1 for one cycle.
- **Full and priority:**
  - DEPTH branches accepted → br_ready=0, and a further br_valid leaves state unchanged.
  - br_valid & res_valid in the same cycle → only the resolve occurs (pht_request=0), and the branch is accepted the following cycle.
- **Empty resolution and async reset:**
  - res_valid with an empty queue → res_ready=0, no pht_result.
  - rst pulsed between clock edges with 2 entries queued → count=0, ghr=0 before the next edge.

Source files
------------

// File: rtl/gshare_index_ctrl_pkg.sv
// Shared widths and checkpoint layout for the gshare index controller.
// A checkpoint entry is {idx, ghr_before, pred}, with pred in the LSB.
package gshare_index_ctrl_pkg;

   localparam int HIST_W_DEF  = 8;
   localparam int PHT_ENTRIES = 1 << HIST_W_DEF;
   localparam int ENTRY_W     = 2 * HIST_W_DEF + 1;

   localparam int PRED_OFS = 0;
   localparam int GHR_OFS  = 1;
   localparam int IDX_OFS  = 1 + HIST_W_DEF;

   function automatic logic [HIST_W_DEF-1:0] gshare_index(
      input logic [HIST_W_DEF-1:0] pc,
      input logic [HIST_W_DEF-1:0] ghr
   );
      return pc ^ ghr;
   endfunction

endpackage

// File: rtl/gshare_index_ctrl_ckpt_fifo.sv
// In-order checkpoint queue for outstanding branches.
// Head data is read combinationally; flush empties the queue in one edge.
module branch_ckpt_fifo
   import gshare_index_ctrl_pkg::*;
#(
   parameter int WIDTH = ENTRY_W,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; validity is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/gshare_index_ctrl.sv
// Gshare PHT initiator: forms idx = pc ^ ghr, checkpoints each branch,
// issues in-order table updates and repairs the GHR on a mispredict.
module gshare_index_ctrl
   import gshare_index_ctrl_pkg::*;
#(
   parameter int HIST_W = HIST_W_DEF,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              br_valid,
   input  logic [HIST_W-1:0] br_pc,
   output logic              br_ready,
   output logic              pred_valid,
   output logic              pred_taken,
   input  logic              res_valid,
   input  logic              res_taken,
   output logic              res_ready,
   output logic              mispredict,
   output logic [HIST_W-1:0] pht_addr,
   output logic              pht_request,
   output logic              pht_result,
   output logic              pht_taken,
   input  logic              pht_prediction
);

   logic [HIST_W-1:0]  ghr_q, ghr_d;
   logic               mispredict_q, mispredict_d;
   logic [ENTRY_W-1:0] head_data;
   logic [ENTRY_W-1:0] push_data;
   logic [HIST_W-1:0]  head_idx;
   logic [HIST_W-1:0]  head_ghr;
   logic               head_pred;
   logic [HIST_W-1:0]  cur_idx;
   logic               fifo_full;
   logic               fifo_empty;
   logic               res_fire;
   logic               pred_fire;
   logic               mis_now;

   assign head_idx  = head_data[IDX_OFS +: HIST_W];
   assign head_ghr  = head_data[GHR_OFS +: HIST_W];
   assign head_pred = head_data[PRED_OFS];
   assign cur_idx   = gshare_index(br_pc, ghr_q);

   // Resolution owns the single table port, so it blocks prediction.
   assign res_ready = ~fifo_empty;
   assign res_fire  = res_valid & ~fifo_empty;
   assign br_ready  = ~fifo_full & ~res_fire;
   assign pred_fire = br_valid & br_ready;
   assign mis_now   = res_fire & (res_taken != head_pred);

   assign pred_valid  = pred_fire;
   assign pred_taken  = pred_fire & pht_prediction;
   assign pht_request = pred_fire;
   assign pht_result  = res_fire;
   assign pht_taken   = res_fire & res_taken;
   assign pht_addr    = res_fire ? head_idx : cur_idx;
   assign mispredict  = mispredict_q;

   assign push_data = {cur_idx, ghr_q, pht_prediction};

   always_comb begin
      ghr_d        = ghr_q;
      mispredict_d = mis_now;
      if (mis_now) begin
         ghr_d = HIST_W'({head_ghr, res_taken});
      end else if (pred_fire) begin
         ghr_d = HIST_W'({ghr_q, pht_prediction});
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr_q        <= '0;
         mispredict_q <= 1'b0;
      end else begin
         ghr_q        <= ghr_d;
         mispredict_q <= mispredict_d;
      end
   end

   branch_ckpt_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_ckpt_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (pred_fire),
      .wr_data_i (push_data),
      .pop_i     (res_fire & ~mis_now),
      .flush_i   (mis_now),
      .head_o    (head_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

endmodule

// File: tb/tb_gshare_index_ctrl.sv
// Directed bench for gshare_index_ctrl; GHR is observed as pht_addr with br_pc=0 while idle.
module tb_gshare_index_ctrl;

   logic       clk;
   logic       rst;
   logic       br_valid;
   logic [7:0] br_pc;
   logic       br_ready;
   logic       pred_valid;
   logic       pred_taken;
   logic       res_valid;
   logic       res_taken;
   logic       res_ready;
   logic       mispredict;
   logic [7:0] pht_addr;
   logic       pht_request;
   logic       pht_result;
   logic       pht_taken;
   logic       pht_prediction;

   int tests_run;
   int tests_failed;

   gshare_index_ctrl #(.HIST_W(8), .DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .br_valid       (br_valid),
      .br_pc          (br_pc),
      .br_ready       (br_ready),
      .pred_valid     (pred_valid),
      .pred_taken     (pred_taken),
      .res_valid      (res_valid),
      .res_taken      (res_taken),
      .res_ready      (res_ready),
      .mispredict     (mispredict),
      .pht_addr       (pht_addr),
      .pht_request    (pht_request),
      .pht_result     (pht_result),
      .pht_taken      (pht_taken),
      .pht_prediction (pht_prediction)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic bv, input logic [7:0] pc, input logic rv,
                        input logic rt, input logic pp);
      br_valid       = bv;
      br_pc          = pc;
      res_valid      = rv;
      res_taken      = rt;
      pht_prediction = pp;
      #1;
   endtask

   task automatic idle_ghr(input string tag, input logic [7:0] exp);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk(tag, 32'(pht_addr), 32'(exp));
   endtask

   task automatic do_reset();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic       pred_seq [3];
   logic [7:0] addr_seq [3];

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst            = 1'b1;
      br_valid       = 1'b0;
      br_pc          = 8'h3C;
      res_valid      = 1'b0;
      res_taken      = 1'b0;
      pht_prediction = 1'b0;

      // Reset state
      #2;
      chk("rst_br_ready",    32'(br_ready),    32'd1);
      chk("rst_res_ready",   32'(res_ready),   32'd0);
      chk("rst_pht_request", 32'(pht_request), 32'd0);
      chk("rst_pht_result",  32'(pht_result),  32'd0);
      chk("rst_pht_addr",    32'(pht_addr),    32'h3C);
      chk("rst_mispredict",  32'(mispredict),  32'd0);
      tick();
      rst = 1'b0;

      // First prediction and correct resolution
      drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
      chk("p1_addr",       32'(pht_addr),    32'h3C);
      chk("p1_request",    32'(pht_request), 32'd1);
      chk("p1_pred_taken", 32'(pred_taken),  32'd1);
      chk("p1_pred_valid", 32'(pred_valid),  32'd1);
      tick();
      idle_ghr("p1_ghr_after", 8'h01);
      chk("p1_res_ready", 32'(res_ready), 32'd1);
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("cr_result",   32'(pht_result),  32'd1);
      chk("cr_addr",     32'(pht_addr),    32'h3C);
      chk("cr_taken",    32'(pht_taken),   32'd1);
      chk("cr_request",  32'(pht_request), 32'd0);
      chk("cr_br_ready", 32'(br_ready),    32'd0);
      tick();
      idle_ghr("cr_ghr_kept", 8'h01);
      chk("cr_mispredict", 32'(mispredict), 32'd0);
      chk("cr_res_ready",  32'(res_ready),  32'd0);

      // Back-to-back predictions from a clean GHR
      do_reset();
      pred_seq = '{1'b1, 1'b0, 1'b1};
      addr_seq = '{8'h10, 8'h11, 8'h12};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'h10, 1'b0, 1'b0, pred_seq[i]);
         chk($sformatf("b2b_addr%0d", i), 32'(pht_addr), 32'(addr_seq[i]));
         chk($sformatf("b2b_req%0d", i),  32'(pht_request), 32'd1);
         tick();
      end
      idle_ghr("b2b_ghr", 8'h05);
      chk("b2b_res_ready", 32'(res_ready), 32'd1);
      chk("b2b_not_full",  32'(br_ready),  32'd1);

      // Mispredict on the oldest entry (idx 0x10, ghr_before 0, pred 1)
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("mp_addr",   32'(pht_addr),   32'h10);
      chk("mp_result", 32'(pht_result), 32'd1);
      chk("mp_taken",  32'(pht_taken),  32'd0);
      tick();
      idle_ghr("mp_ghr_repair", 8'h00);
      chk("mp_pulse",     32'(mispredict), 32'd1);
      chk("mp_flushed",   32'(res_ready),  32'd0);
      tick();
      chk("mp_pulse_end", 32'(mispredict), 32'd0);

      // Fill to DEPTH with not-taken predictions
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
         chk($sformatf("fill_accept%0d", i), 32'(pred_valid), 32'd1);
         tick();
      end
      idle_ghr("full_ghr", 8'h00);
      chk("full_br_ready", 32'(br_ready), 32'd0);
      drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
      chk("full_reject_valid", 32'(pred_valid),  32'd0);
      chk("full_reject_req",   32'(pht_request), 32'd0);
      tick();
      idle_ghr("full_ghr_kept", 8'h00);
      chk("full_still", 32'(br_ready), 32'd0);

      // Simultaneous branch and resolve: resolve wins
      drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
      chk("prio_request",    32'(pht_request), 32'd0);
      chk("prio_result",     32'(pht_result),  32'd1);
      chk("prio_addr",       32'(pht_addr),    32'h20);
      chk("prio_pred_valid", 32'(pred_valid),  32'd0);
      tick();
      drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
      chk("prio_late_ready", 32'(br_ready),    32'd1);
      chk("prio_late_addr",  32'(pht_addr),    32'h55);
      chk("prio_late_req",   32'(pht_request), 32'd1);
      tick();
      idle_ghr("prio_ghr", 8'h01);
      chk("prio_no_mp", 32'(mispredict), 32'd0);

      // Resolution with an empty queue is ignored
      do_reset();
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("empty_res_ready", 32'(res_ready),  32'd0);
      chk("empty_result",    32'(pht_result), 32'd0);
      chk("empty_taken",     32'(pht_taken),  32'd0);
      tick();
      idle_ghr("empty_ghr", 8'h00);
      chk("empty_no_mp", 32'(mispredict), 32'd0);

      // Asynchronous reset with two entries outstanding
      drive(1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
      chk("ar_addr2", 32'(pht_addr), 32'h11);
      tick();
      idle_ghr("ar_ghr_pre", 8'h03);
      chk("ar_res_ready_pre", 32'(res_ready), 32'd1);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      chk("ar_ghr_post",       32'(pht_addr),  32'h00);
      chk("ar_res_ready_post", 32'(res_ready), 32'd0);
      chk("ar_br_ready_post",  32'(br_ready),  32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
